// File: rtl/minialu_nibble_sequencer.sv
// Runs one wide operation through a 4-bit MiniALU, one nibble per cycle,
// least significant nibble first, chaining carry for the selected opcodes.
module minialu_nibble_sequencer #(
  parameter int         NIBBLES   = 2,
  parameter logic [3:0] CARRY_OPS = 4'b0011
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [4*NIBBLES-1:0] req_a,
  input  logic [4*NIBBLES-1:0] req_b,
  input  logic                 req_cin,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [4*NIBBLES-1:0] rsp_c,
  output logic                 rsp_cout,
  output logic                 rsp_sc,
  output logic [1:0]           alu_sel,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic                 alu_cin,
  input  logic [3:0]           alu_c,
  input  logic                 alu_cout,
  input  logic                 alu_sc
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES) + 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [1:0]    op_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  c_q;
  logic          carry_q;
  logic          sc_q;

  logic run;
  logic done;
  logic chain;

  assign run   = (state == RUN);
  assign done  = (state == DONE);
  assign chain = CARRY_OPS[op_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      carry_q <= 1'b0;
      sc_q    <= 1'b0;
    end else begin
      unique case (1'b1)
        state == IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            a_q     <= req_a;
            b_q     <= req_b;
            carry_q <= CARRY_OPS[req_op] & req_cin;
            c_q     <= '0;
            sc_q    <= 1'b0;
            idx     <= '0;
            state   <= RUN;
          end
        end
        state == RUN: begin
          c_q[4*idx +: 4] <= alu_c;
          carry_q         <= chain & alu_cout;
          sc_q            <= alu_sc;
          idx             <= idx + 1'b1;
          if (idx == LAST)
            state <= DONE;
        end
        state == DONE: begin
          if (rsp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ALU pins are only live while a pass is in flight
  assign alu_sel = run ? op_q : 2'b00;
  assign alu_a   = run ? a_q[4*idx +: 4] : 4'h0;
  assign alu_b   = run ? b_q[4*idx +: 4] : 4'h0;
  assign alu_cin = run & carry_q;

  assign req_ready = (state == IDLE) & ~rst;
  assign rsp_valid = done;
  assign rsp_c     = done ? c_q : '0;
  assign rsp_cout  = done & carry_q;
  assign rsp_sc    = done & sc_q;

endmodule
